io_out_display_responder: RTL and testbench
===========================================

Name: io_out_display_responder

Overview:
Responder side of the CPU OUT path. It accepts a 32-bit value from the CPU through a four-phase req/ack handshake. It converts the value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, then drives the unidade/dezena/centena seven-segment displays. Values above MAX_VAL show an overflow pattern instead of digits.

Parameters:
BIN_W, 10, number of binary bits converted (shift iterations); MAX_VAL must fit in BIN_W bits
MAX_VAL, 999, largest value displayable; larger values take the overflow path
ACTIVE_LOW, 1, 1 means a segment is lit by driving 0
BLANK_ZEROS, 1, 1 means leading zeros in centena/dezena are blanked

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
out_req  in  1  CPU request, level; held high until out_ack is seen
out_data  in  32  value to display, unsigned; sampled on accept
out_ack  out  1  one-cycle pulse, transfer accepted
busy  out  1  high from accept until display update completes
valid  out  1  high once the displays hold a converted value
overflow  out  1  last accepted value exceeded MAX_VAL
bcd_unidade  out  4  units digit, BCD
bcd_dezena  out  4  tens digit, BCD
bcd_centena  out  4  hundreds digit, BCD
seg_unidade  out  7  units display; bit0=a ... bit6=g
seg_dezena  out  7  tens display
seg_centena  out  7  hundreds display

Behaviour:
- Reset (async, immediate, any state): state=IDLE; out_ack=0; busy=0; valid=0; overflow=0; all bcd_*=0; all seg_* blank (all segments off per ACTIVE_LOW); armed=0.
- Arming: internal armed flag is set on any clk edge with out_req=0.
  - Accept requires state=IDLE && out_req=1 && armed. Accept clears armed.
  - A req held high through reset or across a completed transfer is not re-accepted until it drops.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, accept at edge k, out_data <= MAX_VAL:
  - Load shift reg {12'b0, out_data[BIN_W-1:0]}; iteration count=0.
  - out_ack=1 during cycle k..k+1 only; busy=1; go to SHIFT.
- IDLE, accept at edge k, out_data > MAX_VAL (full 32-bit unsigned compare):
  - Set ovf_pend; out_ack pulse as above; busy=1; go straight to DONE.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3 (combinational), then the whole register shifts left 1.
  - Count increments.
  - The edge performing shift number BIN_W (edge k+BIN_W) goes to DONE.
- DONE, one edge (k+BIN_W+1 normal, k+1 overflow):
  - Register bcd_* and seg_*; valid=1; overflow=ovf_pend; busy=0; go to IDLE.
  - Outputs change only on this edge and hold until the next DONE or reset.
- Overflow display: all three seg_* show segment g only ("---"). bcd_* = 0.
- Blanking (BLANK_ZEROS=1):
  - centena blank if its digit=0.
  - dezena blank if centena=0 and dezena=0.
  - unidade is always shown (value 0 shows "0").
- Segment encoding: standard 0-9; codes 10-15 never occur and map to blank.
- out_req is ignored while busy; data changes while busy are ignored.
- Latency: accept-to-display is BIN_W+1 cycles (11 by default) normally, 1 cycle on overflow. Throughput is limited by the four-phase handshake.

Test Plan:
1. Reset asserted mid-SHIFT (after accepting 500) -> immediately busy=0, valid=0, segs blank; req still high after release -> no out_ack until req drops and rises again.
2. Accept 123 at edge k -> out_ack one cycle; busy high 11 cycles; at edge k+11: bcd=1/2/3, seg_centena="1", seg_dezena="2", seg_unidade="3", valid=1, overflow=0.
3. Accept 7 -> centena and dezena blank, unidade "7". Accept 0 -> only unidade "0". Accept 40 -> centena blank, dezena "4", unidade "0".
4. Accept 999 -> 9/9/9. Accept 1000 -> at k+1 all displays "---", overflow=1. Accept 32'hFFFF_FFFF -> same. Then accept 5 -> overflow=0, "5".
5. Hold out_req high 30 cycles after ack -> exactly one out_ack. Pulse out_req during busy -> no effect. Back-to-back four-phase transfers 12 then 345 -> displays 12 then 345, each with one out_ack.
6. BLANK_ZEROS=0, ACTIVE_LOW=0 build, accept 5 -> seg_centena/seg_dezena show "0", active-high polarity correct.

Source files
------------

// File: rtl/io_out_display_responder.sv
// CPU OUT-path responder: four-phase req/ack intake, double-dabble binary-to-BCD,
// and registered three-digit seven-segment drive with overflow and zero blanking.
module io_out_display_responder #(
  parameter int BIN_W       = 10,
  parameter int MAX_VAL     = 999,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_ZEROS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        out_req,
  input  logic [31:0] out_data,
  output logic        out_ack,
  output logic        busy,
  output logic        valid,
  output logic        overflow,
  output logic [3:0]  bcd_unidade,
  output logic [3:0]  bcd_dezena,
  output logic [3:0]  bcd_centena,
  output logic [6:0]  seg_unidade,
  output logic [6:0]  seg_dezena,
  output logic [6:0]  seg_centena
);

  localparam int SR_W  = BIN_W + 12;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [6:0] SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_DASH = (ACTIVE_LOW != 0) ? 7'h3F : 7'h40;

  logic [1:0]       state;
  logic             armed;
  logic             ovf_pend;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic             accept;
  logic             is_ovf;
  logic [3:0]       dig_c, dig_d, dig_u;
  logic             blank_c, blank_d;

  function automatic logic [6:0] seg_pol(input logic [6:0] p);
    return (ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // Active-high pattern, bit0=a .. bit6=g; non-decimal codes stay dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] d, input logic blank);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return seg_pol(blank ? 7'h00 : p);
  endfunction

  assign accept  = (state == IDLE) && out_req && armed;
  assign is_ovf  = out_data > 32'(MAX_VAL);
  assign dig_u   = sr[BIN_W +: 4];
  assign dig_d   = sr[BIN_W+4 +: 4];
  assign dig_c   = sr[BIN_W+8 +: 4];
  assign blank_c = (BLANK_ZEROS != 0) && (dig_c == 4'd0);
  assign blank_d = blank_c && (dig_d == 4'd0);

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  // Shift register is pure datapath: loaded on accept, shifted while converting.
  always_ff @(posedge clk) begin
    if (accept)
      sr <= {12'b0, out_data[BIN_W-1:0]};
    else if (state == SHIFT)
      sr <= {sr_adj[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      ovf_pend    <= 1'b0;
      cnt         <= '0;
      out_ack     <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
      bcd_unidade <= 4'd0;
      bcd_dezena  <= 4'd0;
      bcd_centena <= 4'd0;
      seg_unidade <= SEG_OFF;
      seg_dezena  <= SEG_OFF;
      seg_centena <= SEG_OFF;
    end else begin
      out_ack <= accept;
      // A request must be seen low before it can be taken again.
      if (!out_req)
        armed <= 1'b1;
      else if (accept)
        armed <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            cnt      <= '0;
            ovf_pend <= is_ovf;
            state    <= is_ovf ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT)
            state <= DONE;
        end
        DONE: begin
          valid    <= 1'b1;
          overflow <= ovf_pend;
          busy     <= 1'b0;
          state    <= IDLE;
          if (ovf_pend) begin
            bcd_unidade <= 4'd0;
            bcd_dezena  <= 4'd0;
            bcd_centena <= 4'd0;
            seg_unidade <= SEG_DASH;
            seg_dezena  <= SEG_DASH;
            seg_centena <= SEG_DASH;
          end else begin
            bcd_unidade <= dig_u;
            bcd_dezena  <= dig_d;
            bcd_centena <= dig_c;
            seg_unidade <= seg_enc(dig_u, 1'b0);
            seg_dezena  <= seg_enc(dig_d, blank_d);
            seg_centena <= seg_enc(dig_c, blank_c);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_out_display_responder.sv
// Directed bench for io_out_display_responder: default build plus an
// active-high, no-blanking build sharing the clock and reset.
module tb_io_out_display_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        out_req, out_req2;
  logic [31:0] out_data, out_data2;
  logic        out_ack, busy, valid, overflow;
  logic [3:0]  bcd_u, bcd_d, bcd_c;
  logic [6:0]  seg_u, seg_d, seg_c;
  logic        out_ack2, busy2, valid2, overflow2;
  logic [3:0]  bcd_u2, bcd_d2, bcd_c2;
  logic [6:0]  seg_u2, seg_d2, seg_c2;

  int nvec = 0;
  int nerr = 0;
  int acks;

  // Active-high digit patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] BL   = 7'h7F;
  localparam logic [6:0] DASH = 7'h3F;

  io_out_display_responder dut (
    .clk(clk), .reset(reset), .out_req(out_req), .out_data(out_data),
    .out_ack(out_ack), .busy(busy), .valid(valid), .overflow(overflow),
    .bcd_unidade(bcd_u), .bcd_dezena(bcd_d), .bcd_centena(bcd_c),
    .seg_unidade(seg_u), .seg_dezena(seg_d), .seg_centena(seg_c)
  );

  io_out_display_responder #(.BIN_W(10), .MAX_VAL(999), .ACTIVE_LOW(0), .BLANK_ZEROS(0)) dut2 (
    .clk(clk), .reset(reset), .out_req(out_req2), .out_data(out_data2),
    .out_ack(out_ack2), .busy(busy2), .valid(valid2), .overflow(overflow2),
    .bcd_unidade(bcd_u2), .bcd_dezena(bcd_d2), .bcd_centena(bcd_c2),
    .seg_unidade(seg_u2), .seg_dezena(seg_d2), .seg_centena(seg_c2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] c, input logic [3:0] d,
                          input logic [3:0] u, input logic [6:0] sc, input logic [6:0] sd,
                          input logic [6:0] su, input logic ovf);
    chk({tag, "_bcd"}, {bcd_c, bcd_d, bcd_u}, {c, d, u});
    chk({tag, "_seg_c"}, seg_c, sc);
    chk({tag, "_seg_d"}, seg_d, sd);
    chk({tag, "_seg_u"}, seg_u, su);
    chk({tag, "_ovf"}, overflow, ovf);
    chk({tag, "_valid"}, valid, 1'b1);
  endtask

  // Full four-phase transfer on the default instance; lat = accept-to-display cycles.
  task automatic xfer(input logic [31:0] v, input int lat);
    out_req  = 1'b1;
    out_data = v;
    tick;
    chk("ack_rise", out_ack, 1'b1);
    chk("busy_rise", busy, 1'b1);
    out_req = 1'b0;
    for (int i = 1; i < lat; i++) begin
      tick;
      chk("ack_low", out_ack, 1'b0);
      chk("busy_hold", busy, 1'b1);
    end
    tick;
    chk("ack_done", out_ack, 1'b0);
    chk("busy_fall", busy, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    out_req   = 1'b0;
    out_data  = '0;
    out_req2  = 1'b0;
    out_data2 = '0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ack", out_ack, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_bcd", {bcd_c, bcd_d, bcd_u}, 12'h000);
    chk("rst_segs", {seg_c, seg_d, seg_u}, {BL, BL, BL});
    chk("rst_segs2", {seg_c2, seg_d2, seg_u2}, 21'h0);
    tick;
    reset = 1'b0;

    // Reset in the middle of a conversion, with req still high afterwards
    tick;
    out_req  = 1'b1;
    out_data = 32'd500;
    tick;
    chk("r500_ack", out_ack, 1'b1);
    tick;
    tick;
    chk("r500_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ack", out_ack, 1'b0);
    chk("mid_rst_segs", {seg_c, seg_d, seg_u}, {BL, BL, BL});
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("held_req_no_ack", out_ack, 1'b0);
      chk("held_req_idle", busy, 1'b0);
    end
    out_req = 1'b0;
    tick;
    xfer(32'd500, 11);
    chk_disp("d500", 4'd5, 4'd0, 4'd0, ~SEG[5], ~SEG[0], ~SEG[0], 1'b0);

    // Digit and blanking patterns
    xfer(32'd123, 11);
    chk_disp("d123", 4'd1, 4'd2, 4'd3, ~SEG[1], ~SEG[2], ~SEG[3], 1'b0);
    xfer(32'd7, 11);
    chk_disp("d7", 4'd0, 4'd0, 4'd7, BL, BL, ~SEG[7], 1'b0);
    xfer(32'd0, 11);
    chk_disp("d0", 4'd0, 4'd0, 4'd0, BL, BL, ~SEG[0], 1'b0);
    xfer(32'd40, 11);
    chk_disp("d40", 4'd0, 4'd4, 4'd0, BL, ~SEG[4], ~SEG[0], 1'b0);
    xfer(32'd999, 11);
    chk_disp("d999", 4'd9, 4'd9, 4'd9, ~SEG[9], ~SEG[9], ~SEG[9], 1'b0);

    // Overflow path
    xfer(32'd1000, 1);
    chk_disp("d1000", 4'd0, 4'd0, 4'd0, DASH, DASH, DASH, 1'b1);
    xfer(32'hFFFF_FFFF, 1);
    chk_disp("dmax", 4'd0, 4'd0, 4'd0, DASH, DASH, DASH, 1'b1);
    for (int i = 0; i < 3; i++) tick;
    chk_disp("dmax_hold", 4'd0, 4'd0, 4'd0, DASH, DASH, DASH, 1'b1);
    xfer(32'd5, 11);
    chk_disp("d5", 4'd0, 4'd0, 4'd5, BL, BL, ~SEG[5], 1'b0);

    // Request held high long after the acknowledge
    out_req  = 1'b1;
    out_data = 32'd42;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      acks += int'(out_ack);
    end
    chk("hold30_acks", acks, 1);
    chk_disp("d42", 4'd0, 4'd4, 4'd2, BL, ~SEG[4], ~SEG[2], 1'b0);
    out_req = 1'b0;
    tick;

    // A request pulse while busy is ignored
    out_req  = 1'b1;
    out_data = 32'd77;
    tick;
    chk("p77_ack", out_ack, 1'b1);
    out_req = 1'b0;
    tick;
    tick;
    out_req  = 1'b1;
    out_data = 32'd999;
    acks = 0;
    tick;
    acks += int'(out_ack);
    tick;
    acks += int'(out_ack);
    out_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      acks += int'(out_ack);
    end
    chk("pulse_busy_acks", acks, 0);
    chk_disp("d77", 4'd0, 4'd7, 4'd7, BL, ~SEG[7], ~SEG[7], 1'b0);

    // Back-to-back transfers
    xfer(32'd12, 11);
    chk_disp("d12", 4'd0, 4'd1, 4'd2, BL, ~SEG[1], ~SEG[2], 1'b0);
    xfer(32'd345, 11);
    chk_disp("d345", 4'd3, 4'd4, 4'd5, ~SEG[3], ~SEG[4], ~SEG[5], 1'b0);

    // Active-high build without zero blanking
    out_req2  = 1'b1;
    out_data2 = 32'd5;
    tick;
    chk("b2_ack", out_ack2, 1'b1);
    out_req2 = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    chk("b2_busy_hold", busy2, 1'b1);
    tick;
    chk("b2_busy_fall", busy2, 1'b0);
    chk("b2_valid", valid2, 1'b1);
    chk("b2_bcd", {bcd_c2, bcd_d2, bcd_u2}, 12'h005);
    chk("b2_seg_c", seg_c2, SEG[0]);
    chk("b2_seg_d", seg_d2, SEG[0]);
    chk("b2_seg_u", seg_u2, SEG[5]);
    chk("b2_ovf", overflow2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
